// File: rtl/overcurrent_retry_ctrl.sv
// overcurrent_retry_ctrl: gates the H-bridge enable/direction on a debounced
// overcurrent trip, retries after a timed cooldown, decays the retry count
// after a clean run window, and latches a lockout that needs an operator clear.
// Optional build macro OVERCURRENT_BAT_LOCKOUT_EN: battery overcurrent locks
// out immediately instead of being debounced and retried like a motor fault.
module overcurrent_retry_ctrl #(
   parameter int unsigned DEBOUNCE        = 4,
   parameter int unsigned COOLDOWN_CYCLES = 50000,
   parameter int unsigned MAX_RETRIES     = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pwm_in,
   input  logic       dir_in,
   input  logic       over_motor,
   input  logic       over_bat,
   input  logic       clear,
   output logic       en_a,
   output logic [1:0] motor_dir,
   output logic       fault,
   output logic       lockout,
   output logic [2:0] retry_cnt
);

   localparam int unsigned DEB_W = 8;
   localparam int unsigned TMR_W = 20;
   localparam int unsigned CNT_W = 3;

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(COOLDOWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_RETRIES);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   typedef enum logic [1:0] {
      S_RUN  = 2'd0,
      S_TRIP = 2'd1,
      S_COOL = 2'd2,
      S_LOCK = 2'd3
   } state_e;

   state_e           state_q;
   logic             m_meta_q, s_motor_q;
   logic             b_meta_q, s_bat_q;
   logic [DEB_W-1:0] deb_q;
   logic [TMR_W-1:0] tmr_q;
   logic [CNT_W-1:0] retry_q;
   logic             en_q;
   logic [1:0]       dir_q;
   logic             fault_q;
   logic             lock_q;

   logic             oc_c;
   logic             bat_lock_c;
   logic [CNT_W-1:0] retry_d;

   // Fault qualifiers for the selected battery policy and the saturating retry increment
   always_comb begin
`ifdef OVERCURRENT_BAT_LOCKOUT_EN
      oc_c       = s_motor_q;
      bat_lock_c = s_bat_q;
`else
      oc_c       = s_motor_q | s_bat_q;
      bat_lock_c = 1'b0;
`endif
      retry_d = (retry_q == CNT_SAT) ? retry_q : retry_q + CNT_W'(1);
   end

   // Synchronizers, trip/retry/lockout state machine, counters and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RUN;
         m_meta_q  <= 1'b0;
         s_motor_q <= 1'b0;
         b_meta_q  <= 1'b0;
         s_bat_q   <= 1'b0;
         deb_q     <= '0;
         tmr_q     <= '0;
         retry_q   <= '0;
         en_q      <= 1'b0;
         dir_q     <= 2'b00;
         fault_q   <= 1'b0;
         lock_q    <= 1'b0;
      end else begin
         m_meta_q  <= over_motor;
         s_motor_q <= m_meta_q;
         b_meta_q  <= over_bat;
         s_bat_q   <= b_meta_q;
         en_q      <= 1'b0;
         dir_q     <= 2'b00;
         case (state_q)
            S_RUN: begin
               if (bat_lock_c) begin
                  state_q <= S_LOCK;
                  fault_q <= 1'b1;
                  lock_q  <= 1'b1;
                  deb_q   <= '0;
                  tmr_q   <= '0;
               end else if (oc_c && (deb_q == DEB_LAST)) begin
                  state_q <= S_TRIP;
                  fault_q <= 1'b1;
                  deb_q   <= '0;
                  tmr_q   <= '0;
               end else begin
                  en_q  <= pwm_in;
                  dir_q <= {~dir_in, dir_in};
                  if (oc_c) begin
                     deb_q <= deb_q + DEB_W'(1);
                     tmr_q <= '0;
                  end else begin
                     deb_q <= '0;
                     if (tmr_q == TMR_LAST) begin
                        tmr_q   <= '0;
                        retry_q <= '0;
                     end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                     end
                  end
               end
            end
            S_TRIP: begin
               tmr_q <= '0;
               if (bat_lock_c) begin
                  state_q <= S_LOCK;
                  lock_q  <= 1'b1;
               end else begin
                  retry_q <= retry_d;
                  if (retry_d > CNT_MAX) begin
                     state_q <= S_LOCK;
                     lock_q  <= 1'b1;
                  end else begin
                     state_q <= S_COOL;
                  end
               end
            end
            S_COOL: begin
               if (bat_lock_c) begin
                  state_q <= S_LOCK;
                  lock_q  <= 1'b1;
                  tmr_q   <= '0;
               end else if (tmr_q == TMR_LAST) begin
                  tmr_q <= '0;
                  if (!oc_c) begin
                     state_q <= S_RUN;
                     fault_q <= 1'b0;
                  end
               end else begin
                  tmr_q <= tmr_q + TMR_W'(1);
               end
            end
            default: begin
               if (clear && !s_motor_q && !s_bat_q) begin
                  state_q <= S_RUN;
                  retry_q <= '0;
                  fault_q <= 1'b0;
                  lock_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign en_a      = en_q;
   assign motor_dir = dir_q;
   assign fault     = fault_q;
   assign lockout   = lock_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_overcurrent_retry_ctrl.sv
// Bench for overcurrent_retry_ctrl: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle with a behavioural model.
module tb_overcurrent_retry_ctrl;

   localparam int DEB  = 4;
   localparam int CDN  = 16;
   localparam int MAXR = 2;

   localparam int M_RUN  = 0;
   localparam int M_TRIP = 1;
   localparam int M_COOL = 2;
   localparam int M_LOCK = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       pwm_in = 1'b0;
   logic       dir_in = 1'b0;
   logic       over_motor = 1'b0;
   logic       over_bat = 1'b0;
   logic       clear = 1'b0;
   logic       en_a;
   logic [1:0] motor_dir;
   logic       fault;
   logic       lockout;
   logic [2:0] retry_cnt;

   int checks = 0;
   int errors = 0;

   // model state: operating mode, raw-input history for the two-stage sync,
   // run/cool/clean counts and the expected registered outputs
   int       md_mode = M_RUN;
   bit       mm1 = 0, mm2 = 0, mb1 = 0, mb2 = 0;
   int       hi_run = 0, cool_el = 0, clean_run = 0, m_retry = 0;
   bit       e_en = 0;
   bit [1:0] e_dir = 0;
   bit       e_fault = 0, e_lock = 0;

   always #5 clk = ~clk;

   overcurrent_retry_ctrl #(
      .DEBOUNCE       (DEB),
      .COOLDOWN_CYCLES(CDN),
      .MAX_RETRIES    (MAXR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pwm_in    (pwm_in),
      .dir_in    (dir_in),
      .over_motor(over_motor),
      .over_bat  (over_bat),
      .clear     (clear),
      .en_a      (en_a),
      .motor_dir (motor_dir),
      .fault     (fault),
      .lockout   (lockout),
      .retry_cnt (retry_cnt)
   );

   // advance the behavioural model by one rising edge given the inputs seen there
   task automatic model_step(input bit rst, input bit pwm, input bit dir,
                             input bit om, input bit ob, input bit clr);
      bit sm, sb, f, bat;
      int nxt;
      if (rst) begin
         md_mode = M_RUN;
         mm1 = 0; mm2 = 0; mb1 = 0; mb2 = 0;
         hi_run = 0; cool_el = 0; clean_run = 0; m_retry = 0;
         e_en = 0; e_dir = 2'b00; e_fault = 0; e_lock = 0;
      end else begin
         sm = mm2;
         sb = mb2;
`ifdef OVERCURRENT_BAT_LOCKOUT_EN
         bat = sb;
         f   = sm;
`else
         bat = 0;
         f   = sm | sb;
`endif
         nxt = md_mode;
         case (md_mode)
            M_RUN: begin
               if (bat) nxt = M_LOCK;
               else if (f) begin
                  hi_run++;
                  clean_run = 0;
                  if (hi_run == DEB) nxt = M_TRIP;
               end else begin
                  hi_run = 0;
                  clean_run++;
                  if (clean_run == CDN) begin
                     clean_run = 0;
                     m_retry = 0;
                  end
               end
            end
            M_TRIP: begin
               if (bat) nxt = M_LOCK;
               else begin
                  m_retry = (m_retry < 7) ? m_retry + 1 : 7;
                  nxt = (m_retry > MAXR) ? M_LOCK : M_COOL;
               end
            end
            M_COOL: begin
               if (bat) nxt = M_LOCK;
               else begin
                  cool_el++;
                  if (cool_el == CDN) begin
                     cool_el = 0;
                     if (!f) nxt = M_RUN;
                  end
               end
            end
            default: begin
               if (clr && !sm && !sb) begin
                  nxt = M_RUN;
                  m_retry = 0;
               end
            end
         endcase
         if (nxt != md_mode) begin
            hi_run = 0;
            clean_run = 0;
            cool_el = 0;
         end
         e_en    = (md_mode == M_RUN && nxt == M_RUN) ? pwm : 1'b0;
         e_dir   = (md_mode == M_RUN && nxt == M_RUN) ? {~dir, dir} : 2'b00;
         md_mode = nxt;
         e_fault = (nxt != M_RUN);
         e_lock  = (nxt == M_LOCK);
         mm2 = mm1; mm1 = om;
         mb2 = mb1; mb1 = ob;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // hand-computed value: pins both the DUT and the model
   task automatic lit(input string name, input logic [31:0] act, input int mdl, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut: got %0d expected %0d at %0t", name, act, exp, $time);
      end
      checks++;
      if (mdl != exp) begin
         errors++;
         $display("FAIL %s model: got %0d expected %0d at %0t", name, mdl, exp, $time);
      end
   endtask

   // one clock: drive at the falling edge, model at the rising edge, compare at the next falling edge
   task automatic cyc(input bit rst, input bit pwm, input bit dir,
                      input bit om, input bit ob, input bit clr);
      reset = rst; pwm_in = pwm; dir_in = dir;
      over_motor = om; over_bat = ob; clear = clr;
      @(posedge clk);
      model_step(rst, pwm, dir, om, ob, clr);
      @(negedge clk);
      chk("en_a", en_a, e_en);
      chk("motor_dir", motor_dir, e_dir);
      chk("fault", fault, e_fault);
      chk("lockout", lockout, e_lock);
      chk("retry_cnt", retry_cnt, m_retry);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      bit om_lvl, ob_lvl, dir_lvl;
      @(negedge clk);

      // reset state, then sustained motor overcurrent: trip, cooldown, recovery
      do_reset();
      lit("rst_en", en_a, e_en, 0);
      lit("rst_dir", motor_dir, e_dir, 0);
      lit("rst_fault", fault, e_fault, 0);
      lit("rst_lock", lockout, e_lock, 0);
      lit("rst_retry", retry_cnt, m_retry, 0);
      for (int k = 1; k <= 26; k++) begin
         cyc(0, 1, 1, k <= 10, 0, 0);
         if (k == 1)  lit("en_after_rst", en_a, e_en, 1);
         if (k == 5)  lit("en_before_trip", en_a, e_en, 1);
         if (k == 6) begin
            lit("en_trip_edge6", en_a, e_en, 0);
            lit("fault_edge6", fault, e_fault, 1);
         end
         if (k == 7)  lit("retry_after_trip", retry_cnt, m_retry, 1);
         if (k == 22) lit("fault_late_cool", fault, e_fault, 1);
         if (k == 23) lit("fault_back_run", fault, e_fault, 0);
         if (k == 24) lit("en_back_run", en_a, e_en, 1);
      end

      // PWM pass-through with a short glitch below the debounce count
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         cyc(0, k[0], 1, (k >= 4 && k <= 6), 0, 0);
         if (k == 8)  lit("pwm_low", en_a, e_en, 0);
         if (k == 9)  lit("pwm_high_glitch", en_a, e_en, 1);
         if (k == 12) begin
            lit("glitch_fault", fault, e_fault, 0);
            lit("glitch_retry", retry_cnt, m_retry, 0);
            lit("dir_fwd", motor_dir, e_dir, 1);
         end
      end

      // three trips without a clean window: lockout, blocked clear, successful clear
      do_reset();
      for (int k = 1; k <= 75; k++) begin
         cyc(0, 1, 0, (k <= 64) ? (((k - 1) % 22) < 20) : 1'b0, 0, k >= 61);
         if (k == 51) begin
            lit("lock_set", lockout, e_lock, 1);
            lit("lock_retry", retry_cnt, m_retry, 3);
         end
         if (k == 64) lit("clear_blocked", lockout, e_lock, 1);
         if (k == 66) lit("clear_blocked2", lockout, e_lock, 1);
         if (k == 67) begin
            lit("clear_ok", lockout, e_lock, 0);
            lit("clear_retry", retry_cnt, m_retry, 0);
            lit("clear_fault", fault, e_fault, 0);
         end
         if (k == 69) lit("dir_rev", motor_dir, e_dir, 2);
      end

      // short battery overcurrent pulse
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         cyc(0, 1, 1, 0, k <= 3, 0);
`ifdef OVERCURRENT_BAT_LOCKOUT_EN
         if (k == 3)  lit("bat_lock", lockout, e_lock, 1);
         if (k == 10) lit("bat_retry", retry_cnt, m_retry, 0);
`else
         if (k == 10) begin
            lit("bat_no_trip", fault, e_fault, 0);
            lit("bat_retry", retry_cnt, m_retry, 0);
         end
`endif
      end

      // reset during cooldown
      do_reset();
      for (int k = 1; k <= 20; k++) begin
         cyc(k == 15, 1, 1, k <= 14, 0, 0);
         if (k == 14) lit("mid_cool_fault", fault, e_fault, 1);
         if (k == 15) begin
            lit("rst_cool_fault", fault, e_fault, 0);
            lit("rst_cool_retry", retry_cnt, m_retry, 0);
            lit("rst_cool_en", en_a, e_en, 0);
         end
         if (k == 16) lit("rst_cool_en_follow", en_a, e_en, 1);
      end

      // randomized traffic against the model
      om_lvl = 0; ob_lvl = 0; dir_lvl = 1;
      for (int n = 0; n < 5000; n++) begin
         if ($urandom_range(0, 11) == 0) om_lvl = ~om_lvl;
         if (ob_lvl ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 60) == 0)) ob_lvl = ~ob_lvl;
         if ($urandom_range(0, 30) == 0) dir_lvl = ~dir_lvl;
         cyc($urandom_range(0, 700) == 0, 1'($urandom), dir_lvl, om_lvl, ob_lvl,
             $urandom_range(0, 3) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/overcurrent_retry_ctrl.md
OVERCURRENT_RETRY_CTRL -- requirements
Module: overcurrent_retry_ctrl

Interface
REQ-001 Parameter DEBOUNCE, 4: consecutive synchronized overcurrent cycles needed to trip, range 1-255.
REQ-002 Parameter COOLDOWN_CYCLES, 50000: cooldown length and fault-free decay window in clk cycles, range 2 to 2^20-1.
REQ-003 Parameter MAX_RETRIES, 3: automatic restarts allowed before lockout, range 0-6.
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pwm_in  input  1  PWM requested by the speed controller.
REQ-007 dir_in  input  1  requested direction: 1 forward, 0 reverse.
REQ-008 over_motor  input  1  motor overcurrent comparator, asynchronous to clk.
REQ-009 over_bat  input  1  battery overcurrent comparator, asynchronous to clk.
REQ-010 clear  input  1  operator clear from lockout, level-sensitive.
REQ-011 en_a  output  1  gated H-bridge enable, registered.
REQ-012 motor_dir  output  2  H-bridge direction, registered: 01 forward, 10 reverse, 00 coast.
REQ-013 fault  output  1  high in TRIP, COOL or LOCK.
REQ-014 lockout  output  1  high in LOCK only.
REQ-015 retry_cnt  output  3  trips since the last decay or clear.

Function
REQ-016 over_motor and over_bat SHALL each pass through a 2-flop synchronizer (s_motor, s_bat) before any use.
REQ-017 States SHALL be RUN, TRIP, COOL, LOCK, encoded in one state register.
REQ-018 RUN: en_a <= pwm_in, motor_dir <= {~dir_in, dir_in} (1-cycle latency), unless the state leaves RUN on the same edge, in which case en_a <= 0 and motor_dir <= 00.
REQ-019 RUN: the debounce counter increments each cycle s_motor=1 and clears on any cycle s_motor=0; the DEBOUNCE-th consecutive high edge moves the state to TRIP.
REQ-020 With DEBOUNCE=4 and over_motor held high, en_a SHALL be 0 after the 6th rising edge.
REQ-021 TRIP lasts exactly 1 cycle: retry_cnt increments (saturating at 7); next state is LOCK if the new count > MAX_RETRIES, else COOL.
REQ-022 COOL: the timer counts COOLDOWN_CYCLES cycles; at terminal count go to RUN if s_motor=0, else restart the timer and stay in COOL.
REQ-023 LOCK: exit to RUN only when clear=1, s_motor=0 and s_bat=0 on the same edge; retry_cnt clears to 0 on that edge.
REQ-024 In TRIP, COOL and LOCK, en_a and motor_dir SHALL be 0 and 00.
REQ-025 Decay: in RUN, COOLDOWN_CYCLES consecutive cycles with s_motor=0 clear retry_cnt to 0, using the same timer; leaving RUN resets the timer.
REQ-026 clear SHALL be ignored outside LOCK.
REQ-027 Priority on a single edge: battery lockout (REQ-031) > motor trip > decay.

Reset
REQ-028 reset=1 on an edge SHALL set state RUN and clear en_a, motor_dir, retry_cnt, the debounce counter, the timer and both synchronizers; fault=0 and lockout=0.
REQ-029 Reset asserted in any state, including mid-COOL or in LOCK, SHALL take effect on that edge with no residual count.
REQ-030 After reset is released, en_a reflects pwm_in one cycle later.

Configuration
REQ-031 With OVERCURRENT_BAT_LOCKOUT_EN defined: s_bat=1 in RUN, TRIP or COOL moves the state directly to LOCK on that edge, with no debounce and no retry_cnt change.
REQ-032 Without OVERCURRENT_BAT_LOCKOUT_EN: the OR of s_bat and s_motor replaces s_motor in REQ-019, REQ-022 and REQ-025, so a battery fault is debounced and retried like a motor fault.

Verification (DEBOUNCE=4, COOLDOWN_CYCLES=16, MAX_RETRIES=2)
REQ-033 pwm_in toggling, dir_in=1, no faults -> en_a equals pwm_in delayed 1 cycle, motor_dir=01, fault=0.
REQ-034 over_motor high for 3 cycles then low -> no trip, en_a uninterrupted, retry_cnt=0.
REQ-035 over_motor held 10 cycles -> en_a=0 by edge 6, fault=1, retry_cnt=1, then RUN 17 cycles after TRIP, since over_motor is low by then.
REQ-036 Three sustained trips with no 16-cycle clean window -> lockout=1, retry_cnt=3; clear with faults low -> RUN, retry_cnt=0; clear while over_motor high -> remains LOCK.
REQ-037 over_bat pulse of 3 cycles in RUN -> with macro, lockout=1 on edge 3 and retry_cnt unchanged; without macro, no trip since 3 < DEBOUNCE.
REQ-038 reset pulsed on the 8th COOL cycle -> next edge state RUN, retry_cnt=0, en_a=0, then en_a follows pwm_in.
